// File: rtl/prefetch_pkg.sv
// Shared types and address helpers for the instruction prefetch queue.
package prefetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } pf_state_t;

    // Real-mode physical address: (cs << 4) + ip, wrapping at 1 MiB.
    function automatic logic [19:0] phys_addr(input logic [15:0] cs, input logic [15:0] ip);
        return {cs, 4'h0} + {4'h0, ip};
    endfunction

    function automatic logic [18:0] word_addr(input logic [15:0] cs, input logic [15:0] ip);
        return 19'(phys_addr(cs, ip) >> 1);
    endfunction

endpackage

// File: rtl/prefetch_byte_ring.sv
// Circular byte buffer: 0/1/2-byte push and pop per cycle, level count and
// a two-byte head peek. Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module prefetch_byte_ring #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [1:0]                   push_cnt,
    input  logic [15:0]                  push_data,
    input  logic [1:0]                   pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr1, rd_ptr1;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int unsigned s;
        s = 32'(p) + 32'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    always_comb begin
        wr_ptr1 = ptr_add(wr_ptr, 2'd1);
        rd_ptr1 = ptr_add(rd_ptr, 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_cnt != 2'd0) mem[wr_ptr]  <= push_data[7:0];
            if (push_cnt == 2'd2) mem[wr_ptr1] <= push_data[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= ptr_add(wr_ptr, push_cnt);
            rd_ptr <= ptr_add(rd_ptr, pop_cnt);
            level  <= level + LW'(push_cnt) - LW'(pop_cnt);
        end
    end

    // Lanes beyond the current fill level read as zero.
    always_comb begin
        head[7:0]  = (level >= LW'(1)) ? mem[rd_ptr]  : 8'h00;
        head[15:8] = (level >= LW'(2)) ? mem[rd_ptr1] : 8'h00;
    end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch front-end: word fetches at CS:IP into a byte ring with a 2-byte read port.
// Optional PREFETCH_STATS_EN adds saturating fetch/discard counters.
module prefetch_queue
    import prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter logic [15:0] RESET_CS = 16'hFFFF,
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_new_ip,
    input  logic [15:0]                  new_cs,
    input  logic [15:0]                  new_ip,
    output logic [18:0]                  mem_addr,
    output logic                         mem_access,
    input  logic                         mem_ack,
    input  logic [15:0]                  mem_data,
    output logic [15:0]                  rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   rd_level,
    input  logic [1:0]                   rd_pop,
    output logic [15:0]                  rd_ip
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]                  stat_fetches,
    output logic [15:0]                  stat_discards
`endif
);

    localparam int unsigned LW = $clog2(DEPTH + 1);

    pf_state_t     state, state_next;
    logic [15:0]   cs, fetch_ip;
    logic [18:0]   addr_q, cur_word;
    logic [LW-1:0] free_bytes;
    logic          issue, accept, drop;
    logic [1:0]    push_cnt, pop_req, pop_eff;
    logic [15:0]   push_data;

    always_comb begin
        cur_word   = word_addr(cs, fetch_ip);
        free_bytes = LW'(DEPTH) - rd_level;
        issue      = (state == IDLE) && !load_new_ip &&
                     (free_bytes >= (fetch_ip[0] ? LW'(1) : LW'(2)));
        accept     = (state == FETCH) && mem_ack && !load_new_ip;
        drop       = mem_ack && ((state == DISCARD) || ((state == FETCH) && load_new_ip));
        push_cnt   = accept ? (fetch_ip[0] ? 2'd1 : 2'd2) : 2'd0;
        push_data  = fetch_ip[0] ? {8'h00, mem_data[15:8]} : mem_data;
        pop_req    = (rd_pop > 2'd2) ? 2'd2 : rd_pop;
        if (load_new_ip)
            pop_eff = 2'd0;
        else if (LW'(pop_req) > rd_level)
            pop_eff = rd_level[1:0];
        else
            pop_eff = pop_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (issue) state_next = FETCH;
            FETCH:   if (mem_ack) state_next = IDLE;
                     else if (load_new_ip) state_next = DISCARD;
            DISCARD: if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus address is latched at issue so a redirect cannot disturb an in-flight access.
    always_comb begin
        mem_access = (state != IDLE);
        mem_addr   = (state == IDLE) ? cur_word : addr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs       <= RESET_CS;
            fetch_ip <= RESET_IP;
            rd_ip    <= RESET_IP;
            addr_q   <= '0;
        end else begin
            if (issue) addr_q <= cur_word;
            if (load_new_ip) begin
                cs       <= new_cs;
                fetch_ip <= new_ip;
                rd_ip    <= new_ip;
            end else begin
                if (accept) fetch_ip <= fetch_ip + 16'(push_cnt);
                rd_ip <= rd_ip + 16'(pop_eff);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !load_new_ip)
            assert (LW'(rd_pop) <= rd_level);
    end

    prefetch_byte_ring #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .flush    (load_new_ip),
        .push_cnt (push_cnt),
        .push_data(push_data),
        .pop_cnt  (pop_eff),
        .level    (rd_level),
        .head     (rd_data)
    );

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetches  <= '0;
            stat_discards <= '0;
        end else begin
            if (accept && (stat_fetches != '1))  stat_fetches  <= stat_fetches + 32'd1;
            if (drop && (stat_discards != '1))   stat_discards <= stat_discards + 16'd1;
        end
    end
`endif

endmodule
